md_iter_unit: RTL

Iterative, width-parametrised multiply/divide unit for the CPU execute stage. It holds the architectural HI/LO pair and computes one result bit per cycle, replacing fixed-delay behavioural arithmetic. It adds multiply-accumulate and multiply-subtract modes, divide-by-zero reporting, and clean abort on interrupt. The pipeline stalls on `busy`.

---
 rtl/md_pkg.sv | 45 ++++
 rtl/md_div_step.sv | 22 ++
 rtl/md_iter_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared types and opcode decode helpers for the iterative multiply/divide unit.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULTU = 4'd1,
        MD_DIVU  = 4'd2,
        MD_MULT  = 4'd3,
        MD_DIV   = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } md_state_e;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == MD_MULTU) || (op == MD_MULT) || (op == MD_MADD) ||
               (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIVU) || (op == MD_DIV);
    endfunction

    function automatic logic is_signed(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
    endfunction

    function automatic logic is_acc(input logic [3:0] op);
        return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
    endfunction

    function automatic logic is_sub(input logic [3:0] op);
        return (op == MD_MSUB) || (op == MD_MSUBU);
    endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
// Purely combinational.
module md_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] div_i,
    input  logic         bit_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] trial;
    logic [W:0] diff;

    // rem_i < div_i holds, so trial < 2*div_i and the W+1-bit difference cannot wrap.
    assign trial = {rem_i, bit_i};
    assign diff  = trial - {1'b0, div_i};
    assign q_o   = ~diff[W];
    assign rem_o = q_o ? diff[W-1:0] : trial[W-1:0];

endmodule

// File: rtl/md_iter_unit.sv
// Iterative multiply/divide unit owning HI/LO: one result bit per cycle, W+1 cycle latency.
// busy stays high for the whole operation; rupt aborts without touching HI/LO.
module md_iter_unit
    import md_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rupt,
    input  logic         start,
    input  logic [3:0]   md_op,
    input  logic [W-1:0] src1,
    input  logic [W-1:0] src2,
    output logic         busy,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         done,
    output logic         div_zero
);

    localparam int CW = $clog2(W);

    md_state_e       state_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      op_q;
    logic [W-1:0]    a_q;
    logic [2*W-1:0]  acc_q;
    logic [2*W-1:0]  base_q;
    logic            neg_res_q;
    logic            neg_rem_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;
    logic            done_q;
    logic            dz_q;

    logic            s1_neg, s2_neg;
    logic [W-1:0]    s1_mag, s2_mag;
    logic            accept;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  acc_d;
    logic [W-1:0]    div_rem;
    logic            div_q;
    logic [2*W-1:0]  prod_fix;
    logic [2*W-1:0]  mul_res_d;
    logic [W-1:0]    quo_fix, rem_fix;

    assign s1_neg = is_signed(md_op) & src1[W-1];
    assign s2_neg = is_signed(md_op) & src2[W-1];
    assign s1_mag = s1_neg ? -src1 : src1;
    assign s2_mag = s2_neg ? -src2 : src2;
    assign accept = (state_q == IDLE) & start & ~rupt & (is_mul(md_op) | is_div(md_op));

    // acc_q holds {partial product, multiplier} for multiplies and {remainder, dividend/quotient} for divides.
    assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);

    md_div_step #(.W(W)) u_div_step (
        .rem_i (acc_q[2*W-1:W]),
        .div_i (a_q),
        .bit_i (acc_q[W-1]),
        .rem_o (div_rem),
        .q_o   (div_q)
    );

    always_comb begin
        acc_d = {mul_sum, acc_q[W-1:1]};
        if (is_div(op_q)) begin
            acc_d = {div_rem, acc_q[W-2:0], div_q};
        end
    end

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    always_comb begin
        mul_res_d = prod_fix;
        if (is_acc(op_q)) begin
            mul_res_d = is_sub(op_q) ? (base_q - prod_fix) : (base_q + prod_fix);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            acc_q     <= '0;
            base_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= CALC;
                        cnt_q     <= '0;
                        op_q      <= md_op;
                        a_q       <= is_div(md_op) ? s2_mag : s1_mag;
                        acc_q     <= {{W{1'b0}}, (is_div(md_op) ? s1_mag : s2_mag)};
                        base_q    <= {hi_q, lo_q};
                        neg_res_q <= s1_neg ^ s2_neg;
                        neg_rem_q <= s1_neg;
                    end else if (!rupt && md_op == MD_MTHI) begin
                        hi_q <= src1;
                    end else if (!rupt && md_op == MD_MTLO) begin
                        lo_q <= src1;
                    end
                end
                CALC: begin
                    if (rupt) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(W-1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    if (!rupt) begin
                        done_q <= 1'b1;
                        if (is_div(op_q)) begin
                            // Zero divisor spends full latency but leaves HI/LO intact.
                            if (a_q == '0) begin
                                dz_q <= 1'b1;
                            end else begin
                                hi_q <= rem_fix;
                                lo_q <= quo_fix;
                            end
                        end else begin
                            {hi_q, lo_q} <= mul_res_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule
